// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, bridge slave-select bit, wait counter
// width and the completer FSM state type.
package apb_pkg;

  localparam int APB_DATA_W        = 8;
  localparam int APB_BRIDGE_ADDR_W = 9;
  localparam int APB_SEL_BIT       = 8;
  localparam int APB_WAIT_W        = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

endpackage

// File: rtl/apb_regfile_mem.sv
// DEPTH x 8 register storage: synchronous write, combinational read,
// asynchronous clear. Out-of-range addresses read as zero and never write.
module apb_regfile_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [APB_DATA_W-1:0] wdata,
  output logic [APB_DATA_W-1:0] rdata
);

  localparam int AW1   = ADDR_WIDTH + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = AW1'(DEPTH);

  logic [APB_DATA_W-1:0] mem_q [DEPTH];
  logic                  in_range;
  logic [IDX_W-1:0]      idx;

  assign in_range = {1'b0, addr} < DEPTH_LIM;
  assign idx      = addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we && in_range) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = in_range ? mem_q[idx] : '0;

endmodule

// File: rtl/apb_completer_regfile.sv
// APB completer in front of an 8-bit register file: programmable wait
// states, read-only upper region, PSLVERR on illegal accesses.
//
//   state     | meaning
//   ST_IDLE   | no transfer in flight; waiting for a setup phase
//   ST_ACCESS | transfer captured; counting wait states, completes at count 0
module apb_completer_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int RO_BASE     = 48,
  parameter int WAIT_STATES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = AW1'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   RO_LIM    = AW1'(RO_BASE);
  localparam logic [APB_WAIT_W-1:0] WAIT_LOAD = APB_WAIT_W'(WAIT_STATES);

  apb_state_e            state_q, state_d;
  logic [APB_WAIT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;

  logic                  err;
  logic                  mem_we;
  logic [APB_DATA_W-1:0] mem_rdata;

  // A setup phase is honoured in either state: from ACCESS it drops the
  // transfer in flight and restarts with the freshly captured one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    if (PSEL && !PENABLE) begin
      addr_d  = PADDR;
      wdata_d = PWDATA;
      write_d = PWRITE;
      cnt_d   = WAIT_LOAD;
      state_d = ST_ACCESS;
    end else if (state_q == ST_ACCESS) begin
      if (!PSEL) begin
        state_d = ST_IDLE;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - APB_WAIT_W'(1);
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  // PREADY comes only from registered state so it has no input-to-output path.
  assign PREADY = (state_q == ST_ACCESS) && (cnt_q == '0);
  assign err    = ({1'b0, addr_q} >= DEPTH_LIM) ||
                  (write_q && ({1'b0, addr_q} >= RO_LIM));
  assign mem_we = PREADY && PSEL && PENABLE && write_q && !err;

  assign PSLVERR = PREADY && err;
  assign PRDATA  = (PREADY && !err) ? mem_rdata : '0;

  apb_regfile_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Bench for apb_completer_regfile: two instances (2 and 0 wait states) driven
// by scripted APB transfers, checked every cycle against a register-array model.
module tb_apb_completer_regfile;

  logic       clk;
  logic       rst_n;
  logic [1:0] psel;
  logic       penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [1:0] pready, pslverr;
  logic [7:0] prdata [2];

  logic       chk_en;
  logic       exp_rdy [2];
  logic       exp_err [2];
  logic [7:0] exp_rd  [2];
  logic [7:0] mem_m   [2][64];

  int tests = 0;
  int fails = 0;

  int         lat;
  logic [7:0] rd;
  logic       se;

  apb_completer_regfile #(.ADDR_WIDTH(8), .DEPTH(64), .RO_BASE(48), .WAIT_STATES(2)) dut_ws2 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_completer_regfile #(.ADDR_WIDTH(8), .DEPTH(64), .RO_BASE(48), .WAIT_STATES(0)) dut_ws0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_set(input int d, input logic r, input logic e, input logic [7:0] v);
    exp_rdy[d] = r;
    exp_err[d] = e;
    exp_rd[d]  = v;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) mem_m[d][i] = 8'h00;
      exp_set(d, 1'b0, 1'b0, 8'h00);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("pready[%0d]", i),  {31'b0, pready[i]},  {31'b0, exp_rdy[i]});
        chk($sformatf("pslverr[%0d]", i), {31'b0, pslverr[i]}, {31'b0, exp_err[i]});
        chk($sformatf("prdata[%0d]", i),  {24'b0, prdata[i]},  {24'b0, exp_rd[i]});
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      psel = 2'b00; penable = 1'b0;
      exp_set(0, 1'b0, 1'b0, 8'h00);
      exp_set(1, 1'b0, 1'b0, 8'h00);
    end
  endtask

  // Entered 1 time unit after an edge; the setup phase occupies this cycle.
  // Returns 1 unit after the completion edge (or in the abort cycle).
  task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                      input int abort_k, output int l, output logic [7:0] r, output logic e);
    int   ws;
    logic er;
    ws = (d == 0) ? 2 : 0;
    er = (a >= 8'd64) || (wr && a >= 8'd48);
    l = 0; r = 8'h00; e = 1'b0;
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    exp_set(d, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= ws + 1; k++) begin
      @(posedge clk); #1;
      penable = 1'b1;
      paddr   = ~a;
      pwdata  = ~wd;
      if (k == abort_k) begin
        psel[d] = 1'b0; penable = 1'b0;
        exp_set(d, 1'b0, 1'b0, 8'h00);
        return;
      end
      if (l == 0 && pready[d] === 1'b1) begin
        l = k + 1;
        r = prdata[d];
        e = pslverr[d];
      end
      if (k == ws + 1) exp_set(d, 1'b1, er, er ? 8'h00 : mem_m[d][a[5:0]]);
      else             exp_set(d, 1'b0, 1'b0, 8'h00);
    end
    @(posedge clk); #1;
    if (wr && !er) mem_m[d][a[5:0]] = wd;
    psel[d] = 1'b0; penable = 1'b0;
    exp_set(d, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; chk_en = 1'b0;
    psel = 2'b00; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    idle(1);

    // Reset while a write of 0xAA to 0x01 sits in its first wait state.
    psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'hAA;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    chk("rst_pready",  {31'b0, pready[0]},  32'h0);
    chk("rst_pslverr", {31'b0, pslverr[0]}, 32'h0);
    chk("rst_prdata",  {24'b0, prdata[0]},  32'h0);
    @(posedge clk); #1;
    psel = 2'b00; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    xfer(0, 1'b0, 8'h01, 8'h00, 0, lat, rd, se);
    chk("rst_read01", {24'b0, rd}, 32'h00);
    idle(1);

    // Two wait states: write then read 0x02.
    xfer(0, 1'b1, 8'h02, 8'h11, 0, lat, rd, se);
    chk("ws2_wr_lat", lat, 4);
    chk("model_02", {24'b0, mem_m[0][2]}, 32'h11);
    idle(1);
    xfer(0, 1'b0, 8'h02, 8'h00, 0, lat, rd, se);
    chk("ws2_rd_lat", lat, 4);
    chk("ws2_rd02", {24'b0, rd}, 32'h11);
    chk("ws2_rd02_err", {31'b0, se}, 32'h0);
    idle(1);

    // Zero wait states, back-to-back.
    xfer(1, 1'b1, 8'h01, 8'hAA, 0, lat, rd, se);
    chk("ws0_wr01_lat", lat, 2);
    xfer(1, 1'b1, 8'h03, 8'h99, 0, lat, rd, se);
    chk("ws0_wr03_lat", lat, 2);
    xfer(1, 1'b0, 8'h01, 8'h00, 0, lat, rd, se);
    chk("ws0_rd01", {24'b0, rd}, 32'hAA);
    chk("ws0_rd01_lat", lat, 2);
    xfer(1, 1'b0, 8'h03, 8'h00, 0, lat, rd, se);
    chk("ws0_rd03", {24'b0, rd}, 32'h99);
    chk("model_1_03", {24'b0, mem_m[1][3]}, 32'h99);
    idle(1);

    // Read-only region.
    xfer(0, 1'b1, 8'h30, 8'hFF, 0, lat, rd, se);
    chk("ro_wr_err", {31'b0, se}, 32'h1);
    xfer(0, 1'b0, 8'h30, 8'h00, 0, lat, rd, se);
    chk("ro_rd_err", {31'b0, se}, 32'h0);
    chk("ro_rd_data", {24'b0, rd}, 32'h00);
    idle(1);

    // Beyond DEPTH.
    xfer(0, 1'b0, 8'h40, 8'h00, 0, lat, rd, se);
    chk("oor_rd_err", {31'b0, se}, 32'h1);
    chk("oor_rd_data", {24'b0, rd}, 32'h00);
    xfer(0, 1'b1, 8'h45, 8'h12, 0, lat, rd, se);
    chk("oor_wr_err", {31'b0, se}, 32'h1);
    xfer(0, 1'b0, 8'h05, 8'h00, 0, lat, rd, se);
    chk("oor_alias05", {24'b0, rd}, 32'h00);
    idle(1);

    // PSEL dropped in the second wait state of a write.
    xfer(0, 1'b1, 8'h04, 8'hDD, 2, lat, rd, se);
    chk("abort_no_ready", lat, 0);
    idle(2);
    xfer(0, 1'b0, 8'h04, 8'h00, 0, lat, rd, se);
    chk("abort_rd04", {24'b0, rd}, 32'h00);
    xfer(0, 1'b0, 8'h02, 8'h00, 0, lat, rd, se);
    chk("final_rd02", {24'b0, rd}, 32'h11);
    idle(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
